// File: rtl/regfile_wb_arbiter.sv
// Shares one register-file write port between two writeback sources.
// Each source has a small FIFO. A round-robin arbiter drains them onto a registered port.
module regfile_wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s0_valid,
  output logic          s0_ready,
  input  logic [AW-1:0] s0_addr,
  input  logic [DW-1:0] s0_data,
  input  logic          s1_valid,
  output logic          s1_ready,
  input  logic [AW-1:0] s1_addr,
  input  logic [DW-1:0] s1_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr_a,
  input  logic [AW-1:0] rd_addr_b,
  output logic          hazard_a,
  output logic          hazard_b,
  output logic          idle
);
  localparam int PW = $clog2(DEPTH);
  localparam int NS = 2;

  logic [NS-1:0]         vld, rdy, nempty, gnt, hit_a, hit_b;
  logic [NS-1:0][AW-1:0] in_addr, head_addr;
  logic [NS-1:0][DW-1:0] in_data, head_data;

  assign vld     = {s1_valid, s0_valid};
  assign in_addr = {s1_addr, s0_addr};
  assign in_data = {s1_data, s0_data};

  for (genvar g = 0; g < NS; g++) begin : g_src
    logic [DEPTH-1:0][AW-1:0] addr_q;
    logic [DEPTH-1:0][DW-1:0] data_q;
    logic [PW-1:0]            wptr_q, rptr_q;
    logic [PW:0]              cnt_q;
    logic                     push, pop, ha, hb;
    logic [PW-1:0]            off;

    assign rdy[g]       = (cnt_q != (PW+1)'(DEPTH));
    // r0 writes complete the handshake but are never stored.
    assign push         = vld[g] & rdy[g] & (in_addr[g] != '0);
    assign pop          = gnt[g];
    assign nempty[g]    = (cnt_q != '0);
    assign head_addr[g] = addr_q[rptr_q];
    assign head_data[g] = data_q[rptr_q];

    always_ff @(posedge clk) begin
      if (push) begin
        addr_q[wptr_q] <= in_addr[g];
        data_q[wptr_q] <= in_data[g];
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
      end else begin
        if (push) wptr_q <= wptr_q + 1'b1;
        if (pop)  rptr_q <= rptr_q + 1'b1;
        cnt_q <= cnt_q + (PW+1)'(push) - (PW+1)'(pop);
      end
    end

    // An entry is live when its distance from the read pointer is below the count.
    always_comb begin
      ha  = 1'b0;
      hb  = 1'b0;
      off = '0;
      for (int i = 0; i < DEPTH; i++) begin
        off = PW'(i) - rptr_q;
        if ({1'b0, off} < cnt_q) begin
          if (addr_q[i] == rd_addr_a) ha = 1'b1;
          if (addr_q[i] == rd_addr_b) hb = 1'b1;
        end
      end
    end

    assign hit_a[g] = ha;
    assign hit_b[g] = hb;
  end

  assign s0_ready = rdy[0];
  assign s1_ready = rdy[1];

  logic          rr_last_q, rr_last_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;

  always_comb begin
    gnt       = nempty;
    rr_last_d = rr_last_q;
    if (nempty == 2'b11) begin
      gnt       = rr_last_q ? 2'b01 : 2'b10;
      rr_last_d = ~rr_last_q;
    end
    wr_en_d   = |gnt;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (gnt[0]) begin
      wr_addr_d = head_addr[0];
      wr_data_d = head_data[0];
    end else if (gnt[1]) begin
      wr_addr_d = head_addr[1];
      wr_data_d = head_data[1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_last_q <= 1'b1;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      rr_last_q <= rr_last_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

  // The port's current write still counts until the register file commits it.
  assign hazard_a = (rd_addr_a != '0) & ((|hit_a) | (wr_en_q & (wr_addr_q == rd_addr_a)));
  assign hazard_b = (rd_addr_b != '0) & ((|hit_b) | (wr_en_q & (wr_addr_q == rd_addr_b)));
  assign idle     = ~(|nempty) & ~wr_en_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: per-source scoreboards fed at handshake,
// drained against writes captured from the port.
module tb_regfile_wb_arbiter;
  localparam int AW = 5, DW = 32, DEPTH = 2;

  logic          clk = 1'b0, rst = 1'b0;
  logic          s0_valid = 1'b0, s1_valid = 1'b0;
  logic [AW-1:0] s0_addr = '0, s1_addr = '0, rd_addr_a = '0, rd_addr_b = '0;
  logic [DW-1:0] s0_data = '0, s1_data = '0;
  logic          s0_ready, s1_ready, wr_en, hazard_a, hazard_b, idle;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_addr(s0_addr), .s0_data(s0_data),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_addr(s1_addr), .s1_data(s1_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .hazard_a(hazard_a), .hazard_b(hazard_b), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;
  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; int cy; } wr_t;

  ent_t exp_q0[$], exp_q1[$];
  wr_t  cap_q[$];
  int   n_cmp = 0, n_bad = 0, cyc = 0;
  bit   saw_s1_full;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; s0_valid = 1'b0; s1_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_q0.delete(); exp_q1.delete(); cap_q.delete();
  endtask

  // One item on one source; valid is held until accepted, bounded by 50 cycles.
  task automatic push_src(input int src, input logic [AW-1:0] a, input logic [DW-1:0] d, input int stall);
    bit acc; int waited;
    if (stall > 0) begin
      if (src == 0) s0_valid = 1'b0; else s1_valid = 1'b0;
      repeat (stall) @(negedge clk);
    end
    if (src == 0) begin s0_valid = 1'b1; s0_addr = a; s0_data = d; end
    else          begin s1_valid = 1'b1; s1_addr = a; s1_data = d; end
    acc = 1'b0; waited = 0;
    while (!acc && waited < 50) begin
      #1;
      acc = (src == 0) ? s0_ready : s1_ready;
      if (src == 1 && !s1_ready) saw_s1_full = 1'b1;
      @(posedge clk);
      if (acc && a != '0) begin
        if (src == 0) exp_q0.push_back('{a, d}); else exp_q1.push_back('{a, d});
      end
      @(negedge clk);
      waited++;
    end
    if (!acc) begin
      n_cmp++; n_bad++;
      $display("FAIL push_timeout src=%0d got no ready in 50 cycles, required ready=1", src);
    end
  endtask

  task automatic stream(input int src, input int n, input logic [AW-1:0] a,
                        input logic [DW-1:0] base, input int maxstall);
    for (int i = 0; i < n; i++)
      push_src(src, a, base + DW'(i), (maxstall > 0) ? int'($urandom_range(maxstall, 0)) : 0);
    if (src == 0) s0_valid = 1'b0; else s1_valid = 1'b0;
  endtask

  task automatic capture(input int ncyc);
    repeat (ncyc) begin
      @(negedge clk);
      if (wr_en) cap_q.push_back('{wr_addr, wr_data, cyc});
    end
  endtask

  task automatic test_reset();
    bit any_wr;
    rd_addr_a = 5'd3; rd_addr_b = 5'd4;
    #1;
    n_cmp += 4;
    if (wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en got %b want 0", wr_en); end
    if ({s1_ready, s0_ready} !== 2'b11) begin n_bad++; $display("FAIL reset_ready got %b want 11", {s1_ready, s0_ready}); end
    if (idle !== 1'b1) begin n_bad++; $display("FAIL reset_idle got %b want 1", idle); end
    if ({hazard_b, hazard_a} !== 2'b00) begin n_bad++; $display("FAIL reset_hazard got %b want 00", {hazard_b, hazard_a}); end
    @(negedge clk); rst = 1'b1;
    s0_valid = 1'b1; s0_addr = 5'd3; s0_data = 32'h1;
    s1_valid = 1'b1; s1_addr = 5'd4; s1_data = 32'h2;
    @(negedge clk);
    s0_data = 32'h3; s1_data = 32'h4;
    @(negedge clk);
    s0_valid = 1'b0; s1_valid = 1'b0;
    n_cmp += 2;
    if ({hazard_b, hazard_a} !== 2'b11) begin n_bad++; $display("FAIL pre_reset_hazard got %b want 11", {hazard_b, hazard_a}); end
    if (wr_en !== 1'b1) begin n_bad++; $display("FAIL pre_reset_wr_en got %b want 1", wr_en); end
    #2 rst = 1'b0;
    #1;
    n_cmp += 4;
    if (wr_en !== 1'b0) begin n_bad++; $display("FAIL midreset_wr_en got %b want 0", wr_en); end
    if ({s1_ready, s0_ready} !== 2'b11) begin n_bad++; $display("FAIL midreset_ready got %b want 11", {s1_ready, s0_ready}); end
    if (idle !== 1'b1) begin n_bad++; $display("FAIL midreset_idle got %b want 1", idle); end
    if ({hazard_b, hazard_a} !== 2'b00) begin n_bad++; $display("FAIL midreset_hazard got %b want 00", {hazard_b, hazard_a}); end
    @(negedge clk); rst = 1'b1;
    any_wr = 1'b0;
    repeat (6) begin @(negedge clk); if (wr_en) any_wr = 1'b1; end
    n_cmp++;
    if (any_wr !== 1'b0) begin n_bad++; $display("FAIL post_reset_write got %b want 0", any_wr); end
  endtask

  task automatic test_single();
    do_reset();
    rd_addr_a = 5'd5; rd_addr_b = 5'd0;
    s0_valid = 1'b1; s0_addr = 5'd5; s0_data = 32'hDEADBEEF;
    #1;
    n_cmp += 2;
    if (hazard_a !== 1'b0) begin n_bad++; $display("FAIL single_pre_hazard got %b want 0", hazard_a); end
    if (s0_ready !== 1'b1) begin n_bad++; $display("FAIL single_ready got %b want 1", s0_ready); end
    @(negedge clk); s0_valid = 1'b0;
    n_cmp += 3;
    if (wr_en !== 1'b0) begin n_bad++; $display("FAIL single_e0_wr_en got %b want 0", wr_en); end
    if (hazard_a !== 1'b1) begin n_bad++; $display("FAIL single_e0_hazard got %b want 1", hazard_a); end
    if (idle !== 1'b0) begin n_bad++; $display("FAIL single_e0_idle got %b want 0", idle); end
    @(negedge clk);
    n_cmp += 2;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'd5, 32'hDEADBEEF})
      begin n_bad++; $display("FAIL single_write got en=%b a=%0d d=%h want en=1 a=5 d=deadbeef", wr_en, wr_addr, wr_data); end
    if (hazard_a !== 1'b1) begin n_bad++; $display("FAIL single_e1_hazard got %b want 1", hazard_a); end
    @(negedge clk);
    n_cmp += 3;
    if ({wr_en, wr_addr} !== {1'b0, 5'd5}) begin n_bad++; $display("FAIL single_e2_port got en=%b a=%0d want en=0 a=5", wr_en, wr_addr); end
    if (hazard_a !== 1'b0) begin n_bad++; $display("FAIL single_e2_hazard got %b want 0", hazard_a); end
    if (idle !== 1'b1) begin n_bad++; $display("FAIL single_e2_idle got %b want 1", idle); end
  endtask

  task automatic test_contention();
    int src;
    do_reset();
    fork
      stream(0, 4, 5'd1, 32'h10, 0);
      stream(1, 4, 5'd2, 32'h20, 0);
      capture(16);
    join
    n_cmp++;
    if (cap_q.size() != 8) begin n_bad++; $display("FAIL contention_count got %0d want 8", cap_q.size()); end
    foreach (cap_q[i]) begin
      src = -1;
      if (exp_q0.size() > 0 && cap_q[i].a == exp_q0[0].a && cap_q[i].d == exp_q0[0].d) begin void'(exp_q0.pop_front()); src = 0; end
      else if (exp_q1.size() > 0 && cap_q[i].a == exp_q1[0].a && cap_q[i].d == exp_q1[0].d) begin void'(exp_q1.pop_front()); src = 1; end
      n_cmp += 2;
      if (src != (i % 2)) begin n_bad++; $display("FAIL contention_order write %0d a=%0d d=%h from src %0d want src %0d", i, cap_q[i].a, cap_q[i].d, src, i % 2); end
      if (cap_q[i].cy != cap_q[0].cy + i) begin n_bad++; $display("FAIL contention_gap write %0d cycle %0d want %0d", i, cap_q[i].cy, cap_q[0].cy + i); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    saw_s1_full = 1'b0;
    fork
      stream(1, 6, 5'd3, 32'h300, 0);
      stream(0, 6, 5'd6, 32'h600, 0);
      capture(30);
    join
    n_cmp += 2;
    if (saw_s1_full !== 1'b1) begin n_bad++; $display("FAIL bp_s1_ready_drop got %b want 1", saw_s1_full); end
    if (cap_q.size() != 12) begin n_bad++; $display("FAIL bp_count got %0d want 12", cap_q.size()); end
    foreach (cap_q[i]) begin
      n_cmp++;
      if (exp_q0.size() > 0 && cap_q[i].a == exp_q0[0].a && cap_q[i].d == exp_q0[0].d) void'(exp_q0.pop_front());
      else if (exp_q1.size() > 0 && cap_q[i].a == exp_q1[0].a && cap_q[i].d == exp_q1[0].d) void'(exp_q1.pop_front());
      else begin n_bad++; $display("FAIL bp_data write %0d got a=%0d d=%h, not next expected from either source", i, cap_q[i].a, cap_q[i].d); end
    end
    n_cmp++;
    if (exp_q0.size() + exp_q1.size() != 0) begin n_bad++; $display("FAIL bp_lost got %0d pending want 0", exp_q0.size() + exp_q1.size()); end
  endtask

  task automatic test_r0();
    bit any_wr, any_busy, any_haz;
    do_reset();
    rd_addr_a = 5'd0;
    s0_valid = 1'b1; s0_addr = 5'd0; s0_data = 32'hFFFFFFFF;
    #1;
    n_cmp++;
    if (s0_ready !== 1'b1) begin n_bad++; $display("FAIL r0_ready got %b want 1", s0_ready); end
    @(negedge clk); s0_valid = 1'b0;
    any_wr = 1'b0; any_busy = 1'b0; any_haz = 1'b0;
    repeat (5) begin
      if (wr_en) any_wr = 1'b1;
      if (!idle) any_busy = 1'b1;
      if (hazard_a) any_haz = 1'b1;
      @(negedge clk);
    end
    n_cmp += 3;
    if (any_wr !== 1'b0) begin n_bad++; $display("FAIL r0_write got %b want 0", any_wr); end
    if (any_busy !== 1'b0) begin n_bad++; $display("FAIL r0_idle_drop got %b want 0", any_busy); end
    if (any_haz !== 1'b0) begin n_bad++; $display("FAIL r0_hazard got %b want 0", any_haz); end
  endtask

  task automatic test_wrap();
    do_reset();
    fork
      stream(1, 10, 5'd7, 32'h100, 0);
      stream(0, 5, 5'd9, 32'h200, 3);
      capture(60);
    join
    n_cmp++;
    if (cap_q.size() != 15) begin n_bad++; $display("FAIL wrap_count got %0d want 15", cap_q.size()); end
    foreach (cap_q[i]) begin
      n_cmp++;
      if (exp_q0.size() > 0 && cap_q[i].a == exp_q0[0].a && cap_q[i].d == exp_q0[0].d) void'(exp_q0.pop_front());
      else if (exp_q1.size() > 0 && cap_q[i].a == exp_q1[0].a && cap_q[i].d == exp_q1[0].d) void'(exp_q1.pop_front());
      else begin n_bad++; $display("FAIL wrap_order write %0d got a=%0d d=%h, not next in push order", i, cap_q[i].a, cap_q[i].d); end
    end
    n_cmp++;
    if (exp_q0.size() + exp_q1.size() != 0) begin n_bad++; $display("FAIL wrap_lost got %0d pending want 0", exp_q0.size() + exp_q1.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_r0();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
